bwm_mul_arbiter: RTL and testbench

//  Shares one signed Baugh-Wooley W x W multiplier core between two requesters.

---
 rtl/bwm_mul_arbiter.sv | 89 ++++++++
 tb/tb_bwm_mul_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/bwm_mul_arbiter.sv
// bwm_mul_arbiter: round-robin share of one signed Baugh-Wooley WxW multiplier between two requesters
// Define BWM_ARB_STATS_EN to add saturating per-requester grant counters.
module bwm_mul_arbiter #(
  parameter int W = 4
`ifdef BWM_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_p
`ifdef BWM_ARB_STATS_EN
  , output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;
  // Baugh-Wooley correction constant 2^(2W-1) + 2^W
  localparam logic [2*W-1:0] BW_K = ((2*W)'(1) << (2*W-1)) | ((2*W)'(1) << W);
  state_t state_q, state_d;
  logic ptr_q, ptr_d, id_q, id_d;
  logic [2*W-1:0] p_q, p_d, bw_p;
  logic [W-1:0] op_a, op_b;
  logic gnt0, gnt1, accept_ok, acc0, acc1, acc;
  assign gnt0 = req0_valid & (~req1_valid | ~ptr_q);
  assign gnt1 = req1_valid & (~req0_valid | ptr_q);
  assign accept_ok = (state_q == EMPTY) | rsp_ready;
  assign req0_ready = accept_ok & gnt0;
  assign req1_ready = accept_ok & gnt1;
  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  assign acc = acc0 | acc1;
  assign op_a = gnt1 ? req1_a : req0_a;
  assign op_b = gnt1 ? req1_b : req0_b;
  assign rsp_valid = (state_q == FULL);
  assign rsp_id = id_q;
  assign rsp_p = p_q;
  // Partial products touching exactly one sign bit are inverted
  always_comb begin
    bw_p = BW_K;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        bw_p = bw_p + ((2*W)'((op_a[i] & op_b[j]) ^ ((i == W-1) != (j == W-1))) << (i + j));
  end
  always_comb begin
    state_d = acc ? FULL : (rsp_ready ? EMPTY : state_q);
    ptr_d = acc ? acc0 : ptr_q;
    id_d = acc ? acc1 : id_q;
    p_d = acc ? bw_p : p_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q <= 1'b0;
      id_q <= 1'b0;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      p_q <= p_d;
    end
  end
`ifdef BWM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0 && cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
      if (acc1 && cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
    end
  end
  assign gnt0_cnt = cnt0_q;
  assign gnt1_cnt = cnt1_q;
`endif
endmodule

// File: tb/tb_bwm_mul_arbiter.sv
// tb_bwm_mul_arbiter: directed vector table plus exhaustive and reset sequences for bwm_mul_arbiter
module tb_bwm_mul_arbiter;
  typedef struct {
    logic v0; logic [3:0] a0, b0;
    logic v1; logic [3:0] a1, b1;
    logic rr;
    logic er0, er1, ev, eid; logic [7:0] ep;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [7:0] rsp_p;
  int checks = 0, failures = 0;
  vec_t tbl [20];
  always #5 clk = ~clk;
`ifdef BWM_ARB_STATS_EN
  logic [1:0] gnt0_cnt, gnt1_cnt;
  bwm_mul_arbiter #(.W(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt));
`else
  bwm_mul_arbiter #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p));
`endif
  task automatic chk(input string name, input int n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, n, act, exp);
    end
  endtask
  task automatic step(input vec_t v, input string name, input int n);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    rsp_ready = v.rr;
    #1;
    chk({name, "_rdy0"}, n, 16'(req0_ready), 16'(v.er0));
    chk({name, "_rdy1"}, n, 16'(req1_ready), 16'(v.er1));
    @(posedge clk);
    #1;
    chk({name, "_vld"}, n, 16'(rsp_valid), 16'(v.ev));
    chk({name, "_id"}, n, 16'(rsp_id), 16'(v.eid));
    chk({name, "_p"}, n, 16'(rsp_p), 16'(v.ep));
  endtask
  initial begin
    tbl[0]  = '{1, 4'h2, 4'h3, 1, 4'hF, 4'h5, 1, 1, 0, 1, 0, 8'h06};
    tbl[1]  = '{1, 4'h2, 4'h3, 1, 4'hF, 4'h5, 1, 0, 1, 1, 1, 8'hFB};
    tbl[2]  = '{1, 4'h8, 4'h8, 1, 4'h7, 4'h7, 1, 1, 0, 1, 0, 8'h40};
    tbl[3]  = '{1, 4'h8, 4'h7, 1, 4'h7, 4'h7, 1, 0, 1, 1, 1, 8'h31};
    tbl[4]  = '{0, 4'h0, 4'h0, 1, 4'h3, 4'hE, 1, 0, 1, 1, 1, 8'hFA};
    for (int i = 5; i < 10; i++)
      tbl[i] = '{1, 4'h1, 4'h1, 1, 4'h2, 4'h2, 0, 0, 0, 1, 1, 8'hFA};
    tbl[10] = '{1, 4'h1, 4'h1, 1, 4'h2, 4'h2, 1, 1, 0, 1, 0, 8'h01};
    tbl[11] = '{1, 4'h4, 4'h4, 0, 4'h0, 4'h0, 1, 1, 0, 1, 0, 8'h10};
    tbl[12] = '{0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 8'h10};
    tbl[13] = '{1, 4'h5, 4'h5, 1, 4'hD, 4'h3, 1, 0, 1, 1, 1, 8'hF7};
    tbl[14] = '{1, 4'h5, 4'h5, 1, 4'hD, 4'h3, 1, 1, 0, 1, 0, 8'h19};
    tbl[15] = '{1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 8'h19};
    tbl[16] = '{1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 1, 1, 0, 1, 0, 8'h01};
    tbl[17] = '{0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 8'h01};
    tbl[18] = '{0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 8'h01};
    tbl[19] = '{0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 8'h01};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vld", 0, 16'(rsp_valid), 16'h0);
    chk("reset_id", 0, 16'(rsp_id), 16'h0);
    chk("reset_p", 0, 16'(rsp_p), 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(tbl[i], "tbl", i);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        logic [3:0] av, bv;
        logic signed [7:0] m;
        av = 4'(a); bv = 4'(b);
        m = $signed(av) * $signed(bv);
        step('{1, av, bv, 0, 4'h0, 4'h0, 1, 1, 0, 1, 0, m}, "exh", a * 16 + b);
      end
    step('{1, 4'h2, 4'h2, 0, 4'h0, 4'h0, 1, 1, 0, 1, 0, 8'h04}, "rst_fill", 0);
    req0_valid = 0; rsp_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 0, 16'(rsp_valid), 16'h0);
    chk("async_rst_p", 0, 16'(rsp_p), 16'h0);
    chk("async_rst_id", 0, 16'(rsp_id), 16'h0);
    #1 rst_n = 1'b1;
    step('{1, 4'h3, 4'h3, 1, 4'h1, 4'h1, 1, 1, 0, 1, 0, 8'h09}, "post_rst", 0);
    step('{1, 4'h3, 4'h3, 1, 4'h1, 4'h1, 1, 0, 1, 1, 1, 8'h01}, "post_rst", 1);
`ifdef BWM_ARB_STATS_EN
    rst_n = 1'b0;
    #1;
    chk("cnt0_rst", 0, 16'(gnt0_cnt), 16'h0);
    chk("cnt1_rst", 0, 16'(gnt1_cnt), 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step('{1, 4'h1, 4'h2, 0, 4'h0, 4'h0, 1, 1, 0, 1, 0, 8'h02}, "cnt_fill", i);
      chk("cnt0", i, 16'(gnt0_cnt), 16'(i < 3 ? i + 1 : 3));
    end
    chk("cnt1", 0, 16'(gnt1_cnt), 16'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
